note_entry_ctrl: RTL and testbench
==================================

Name: note_entry_ctrl

Overview:
- Front-end stage that turns raw panel inputs into the note/tone/ok stream consumed by the sequence-recognition FSM.
- Inputs: seven note keys, one tone switch and one confirm button.
- Synchronises and debounces every input, then encodes the pressed key to the 3-bit note code.
- Issues exactly one single-cycle ok pulse per confirm press, with note/tone registered and stable. The recognizer advances once per cycle that ok is high, so pulse width is critical.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronised input must differ from its debounced value before that value flips (min 1; silicon builds use 500000)
CNT_W, 19, width of each debounce counter; must hold DEBOUNCE_CYCLES-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
key_raw  in  7  raw note keys, active-high; bit0=C, bit1=D, bit2=E, bit3=F, bit4=G, bit5=A, bit6=B
tone_raw  in  1  raw tone switch
confirm_raw  in  1  raw confirm button, active-high
ok  out  1  one-cycle pulse: note/tone valid this cycle
note  out  3  registered note code; 000=rest/none, 001=C … 111=B
tone  out  1  registered tone bit
key_err  out  1  one-cycle pulse: confirm pressed with more than one key held
entry_count  out  4  number of ok pulses issued since reset, saturating at 15

Behaviour:
- Reset (sync, active-high): all synchroniser flops, debounced values, counters and outputs go to 0; FSM goes to IDLE. Reset overrides all other activity, including mid-debounce or mid-press.
- Each of the 9 inputs passes through a 2-flop synchroniser, then a debouncer:
  - s == stable: cnt <= 0.
  - s != stable and cnt == DEBOUNCE_CYCLES-1: stable <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never reaches stable.
- Encoder (combinational on debounced keys):
  - exactly one key set: note code = index+1;
  - no key set: 000;
  - two or more keys set: multi = 1.
- Confirm rising edge: conf_rise = conf_stable & ~conf_prev; conf_prev is registered every cycle.
- FSM, 2 states:
  - IDLE, conf_rise & ~multi: note <= encoded code, tone <= tone_stable, ok <= 1, entry_count <= sat(entry_count+1); go to WAIT_REL.
  - IDLE, conf_rise & multi: key_err <= 1; note, tone and ok unchanged (ok stays 0); go to WAIT_REL.
  - WAIT_REL: ok <= 0 and key_err <= 0 every cycle; return to IDLE when conf_stable == 0.
- Latency: with raw confirm and key stable before edge 0, ok is high for exactly the cycle between edges DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+3.
- note and tone hold their last captured values between pulses. Key or tone changes while in WAIT_REL are ignored.
- Confirm held indefinitely: a single ok; no auto-repeat.
- Confirm with no key held: legal. Captures note=000 (rest) with ok=1.
- entry_count stays at 15 on further ok pulses. ok is still issued.
- Confirm held through reset: the debounced value restarts at 0, so one ok is issued DEBOUNCE_CYCLES+2 edges after reset deasserts. This is defined behaviour.

Decomposition:
- Shared package: note codes (NOTE_X=000 … NOTE_B=111) and the FSM state encoding, both reused by the recognizer and its bench.
- Sub-module `debounce` (sync + counter, parameter DEBOUNCE_CYCLES), instantiated 9 times.

Test Plan:
- DEBOUNCE_CYCLES=4; hold key_raw=0001000 (F), tone_raw=0, pulse confirm_raw high 20 cycles → ok high exactly 1 cycle between edges 6 and 7; note=100, tone=0; entry_count=1.
- Same press with confirm_raw held 200 cycles → exactly one ok; release then re-press with key_raw=1000000, tone_raw=1 → second ok with note=111, tone=1, entry_count=2.
- confirm_raw toggling every 2 cycles for 40 cycles (bounce) → no ok; then held high → single ok.
- key_raw=0000011 with confirm pressed → key_err 1-cycle pulse, ok=0, note/tone unchanged.
- key_raw=0 with confirm pressed → ok with note=000; 16 further valid presses → entry_count stays 15, ok still pulses.
- reset asserted during WAIT_REL with confirm held → all outputs 0 next cycle; ok re-issued once at edge 6 after reset deasserts.

Source files
------------

// File: rtl/note_entry_ctrl_pkg.sv
// Shared note codes and entry FSM states for the note-entry front end and the
// sequence recognizer downstream of it.
package note_entry_ctrl_pkg;

  typedef enum logic [2:0] {
    NOTE_X = 3'b000,
    NOTE_C = 3'b001,
    NOTE_D = 3'b010,
    NOTE_E = 3'b011,
    NOTE_F = 3'b100,
    NOTE_G = 3'b101,
    NOTE_A = 3'b110,
    NOTE_B = 3'b111
  } note_t;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_REL = 1'b1
  } state_t;

  // Key index i maps to note code i+1; only meaningful when at most one key is set.
  function automatic note_t encode_key(input logic [6:0] keys);
    note_t code;
    code = NOTE_X;
    for (int i = 0; i < 7; i++) begin
      if (keys[i]) code = note_t'(3'(i + 1));
    end
    return code;
  endfunction

  function automatic logic multi_key(input logic [6:0] keys);
    return (keys & (keys - 7'd1)) != 7'd0;
  endfunction

endpackage

// File: rtl/note_entry_ctrl_debounce.sv
// Two-flop synchroniser followed by a counter debouncer: the output only
// follows the input after DEBOUNCE_CYCLES consecutive differing cycles.
module debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 19
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic stable
);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/note_entry_ctrl.sv
// Panel front end: debounces keys/tone/confirm and emits one ok pulse per
// confirm press with the selected note and tone registered alongside it.
module note_entry_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 19
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] key_raw,
  input  logic       tone_raw,
  input  logic       confirm_raw,
  output logic       ok,
  output logic [2:0] note,
  output logic       tone,
  output logic       key_err,
  output logic [3:0] entry_count
);
  import note_entry_ctrl_pkg::*;

  logic [6:0] key_stable;
  logic       tone_stable;
  logic       conf_stable;
  logic       conf_prev;
  logic       conf_rise;
  logic       multi;
  note_t      enc_note;
  state_t     state;

  for (genvar i = 0; i < 7; i++) begin : g_key
    debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_key (
      .clk(clk), .reset(reset), .raw(key_raw[i]), .stable(key_stable[i])
    );
  end

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_tone (
    .clk(clk), .reset(reset), .raw(tone_raw), .stable(tone_stable)
  );

  debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_conf (
    .clk(clk), .reset(reset), .raw(confirm_raw), .stable(conf_stable)
  );

  assign enc_note  = encode_key(key_stable);
  assign multi     = multi_key(key_stable);
  assign conf_rise = conf_stable & ~conf_prev;

  // ok/key_err are cleared on every cycle after capture, so each press yields a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      conf_prev   <= 1'b0;
      ok          <= 1'b0;
      key_err     <= 1'b0;
      note        <= 3'b000;
      tone        <= 1'b0;
      entry_count <= 4'd0;
    end else begin
      conf_prev <= conf_stable;
      ok        <= 1'b0;
      key_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (conf_rise) begin
            if (multi) begin
              key_err <= 1'b1;
            end else begin
              note <= enc_note;
              tone <= tone_stable;
              ok   <= 1'b1;
              if (entry_count != 4'hF) entry_count <= entry_count + 4'd1;
            end
            state <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (!conf_stable) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_entry_ctrl.sv
// Directed bench for note_entry_ctrl: table of confirm presses plus hand
// sequences for bounce, counter saturation and reset during a held press.
module tb_note_entry_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] key_raw;
  logic       tone_raw;
  logic       confirm_raw;
  logic       ok;
  logic [2:0] note;
  logic       tone;
  logic       key_err;
  logic [3:0] entry_count;

  int checks   = 0;
  int failures = 0;

  note_entry_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(19)) dut (
    .clk(clk), .reset(reset), .key_raw(key_raw), .tone_raw(tone_raw),
    .confirm_raw(confirm_raw), .ok(ok), .note(note), .tone(tone),
    .key_err(key_err), .entry_count(entry_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] key;
    logic       tone;
    int         hold;
    int         exp_ok;
    int         exp_err;
    logic [2:0] exp_note;
    logic       exp_tone;
    logic [3:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  int ok_n, ok_edge, err_n, err_edge;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Edges are numbered from the first posedge after confirm_raw rises.
  task automatic sampleCycles(input int n);
    for (int c = 0; c < n; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ok) begin
        ok_n++;
        if (ok_n == 1) ok_edge = c;
      end
      if (key_err) begin
        err_n++;
        if (err_n == 1) err_edge = c;
      end
    end
  endtask

  task automatic applyStimulus(input logic [6:0] k, input logic t, input int hold);
    ok_n = 0; ok_edge = -1; err_n = 0; err_edge = -1;
    key_raw  = k;
    tone_raw = t;
    sampleCycles(8);
    ok_n = 0; ok_edge = -1; err_n = 0; err_edge = -1;
    confirm_raw = 1'b1;
    sampleCycles(hold);
    confirm_raw = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ok) ok_n++;
      if (key_err) err_n++;
    end
  endtask

  int exp_count;

  initial begin
    vecs[0] = '{7'b0001000, 1'b0, 20,  1, 0, 3'b100, 1'b0, 4'd1};
    vecs[1] = '{7'b0001000, 1'b0, 200, 1, 0, 3'b100, 1'b0, 4'd2};
    vecs[2] = '{7'b1000000, 1'b1, 20,  1, 0, 3'b111, 1'b1, 4'd3};
    vecs[3] = '{7'b0000011, 1'b0, 20,  0, 1, 3'b111, 1'b1, 4'd3};
    vecs[4] = '{7'b0000000, 1'b1, 20,  1, 0, 3'b000, 1'b1, 4'd4};
    vecs[5] = '{7'b0000001, 1'b0, 20,  1, 0, 3'b001, 1'b0, 4'd5};
    vecs[6] = '{7'b0100000, 1'b1, 20,  1, 0, 3'b110, 1'b1, 4'd6};
    vecs[7] = '{7'b1110000, 1'b0, 20,  0, 1, 3'b110, 1'b1, 4'd6};

    reset = 1'b1; key_raw = '0; tone_raw = 1'b0; confirm_raw = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_ok", ok, 0);
    checkOutput("reset_note", note, 0);
    checkOutput("reset_tone", tone, 0);
    checkOutput("reset_key_err", key_err, 0);
    checkOutput("reset_count", entry_count, 0);
    reset = 1'b0;

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].key, vecs[v].tone, vecs[v].hold);
      checkOutput($sformatf("v%0d_ok_pulses", v), ok_n, vecs[v].exp_ok);
      checkOutput($sformatf("v%0d_err_pulses", v), err_n, vecs[v].exp_err);
      if (vecs[v].exp_ok == 1) checkOutput($sformatf("v%0d_ok_edge", v), ok_edge, 6);
      if (vecs[v].exp_err == 1) checkOutput($sformatf("v%0d_err_edge", v), err_edge, 6);
      checkOutput($sformatf("v%0d_note", v), note, vecs[v].exp_note);
      checkOutput($sformatf("v%0d_tone", v), tone, vecs[v].exp_tone);
      checkOutput($sformatf("v%0d_count", v), entry_count, vecs[v].exp_count);
    end

    // Confirm bouncing with a 2-cycle half period never survives debounce.
    key_raw = 7'b0010000; tone_raw = 1'b0;
    ok_n = 0; ok_edge = -1; err_n = 0; err_edge = -1;
    for (int c = 0; c < 40; c++) begin
      confirm_raw = ((c / 2) % 2) == 0;
      sampleCycles(1);
    end
    confirm_raw = 1'b0;
    sampleCycles(8);
    checkOutput("bounce_no_ok", ok_n, 0);
    applyStimulus(7'b0010000, 1'b0, 20);
    checkOutput("bounce_then_hold_ok", ok_n, 1);
    checkOutput("bounce_then_hold_edge", ok_edge, 6);
    checkOutput("bounce_note", note, 3'b101);
    checkOutput("bounce_count", entry_count, 7);

    // Counter saturates at 15 while ok keeps pulsing.
    exp_count = 7;
    for (int p = 0; p < 10; p++) begin
      applyStimulus(7'b0000100, p[0], 16);
      if (exp_count < 15) exp_count++;
      checkOutput($sformatf("sat%0d_ok", p), ok_n, 1);
      checkOutput($sformatf("sat%0d_count", p), entry_count, exp_count);
    end
    checkOutput("sat_final_count", entry_count, 15);
    checkOutput("sat_note", note, 3'b011);

    // Reset while held in WAIT_REL, confirm still down throughout.
    key_raw = 7'b0001000; tone_raw = 1'b1;
    sampleCycles(8);
    ok_n = 0; ok_edge = -1; err_n = 0; err_edge = -1;
    confirm_raw = 1'b1;
    sampleCycles(10);
    checkOutput("prereset_ok", ok_n, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midreset_ok", ok, 0);
    checkOutput("midreset_note", note, 0);
    checkOutput("midreset_tone", tone, 0);
    checkOutput("midreset_key_err", key_err, 0);
    checkOutput("midreset_count", entry_count, 0);
    reset = 1'b0;
    ok_n = 0; ok_edge = -1; err_n = 0; err_edge = -1;
    sampleCycles(30);
    checkOutput("postreset_ok_pulses", ok_n, 1);
    checkOutput("postreset_ok_edge", ok_edge, 6);
    checkOutput("postreset_note", note, 3'b100);
    checkOutput("postreset_tone", tone, 1);
    checkOutput("postreset_count", entry_count, 1);
    confirm_raw = 1'b0;
    sampleCycles(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
